// File: rtl/router_reg_p.sv
// Packet register stage of the 1xN router: header capture, FIFO write data, one-word stall buffer,
// XOR parity check. Define ROUTER_REG_LEN_CHECK_EN to add a payload-length check that feeds err.
module router_reg_p #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              err,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic [DATA_W-1:0] dout,
  output logic              len_err
);

  localparam int              LEN_W      = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] int_par_q, int_par_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;

  logic addr_ok;
  logic par_cap_ld;
  logic par_cap_laf;
  logic par_cap;
  logic word_acc;

  // Address is zero-extended by one bit so NUM_PORTS == 2**ADDR_W accepts every address.
  assign addr_ok     = ({1'b0, data_in[ADDR_W-1:0]} < PORT_LIMIT);
  assign par_cap_ld  = ld_state & ~pkt_valid & ~fifo_full;
  assign par_cap_laf = laf_state & low_pkt_valid_q & ~parity_done_q;
  assign par_cap     = par_cap_ld | par_cap_laf;
  assign word_acc    = ld_state & pkt_valid & ~full_state;

  always_comb begin
    hdr_d           = hdr_q;
    hold_d          = hold_q;
    dout_d          = dout_q;
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (detect_add && pkt_valid && addr_ok) begin
      hdr_d = data_in;
    end

    if (lfd_state) begin
      dout_d = hdr_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (ld_state && fifo_full) begin
      hold_d = data_in;
    end else if (laf_state) begin
      dout_d = hold_q;
    end

    if (detect_add) begin
      int_par_d = '0;
    end else if (lfd_state) begin
      int_par_d = hdr_q;
    end else if (word_acc) begin
      int_par_d = int_par_q ^ data_in;
    end

    if (par_cap_ld) begin
      pkt_par_d = data_in;
    end else if (par_cap_laf) begin
      pkt_par_d = hold_q;
    end

    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (par_cap) begin
      parity_done_d = 1'b1;
    end

    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end

    // err compares registered parities, so it settles one cycle after parity_done.
    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_par_q != pkt_par_q) | len_err;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q           <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  // Counts accepted payload words; saturates so an over-long packet still mismatches.
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (detect_add) begin
      cnt_d     = '0;
      len_err_d = 1'b0;
    end else begin
      if (word_acc && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (par_cap) begin
        len_err_d = (cnt_q != hdr_q[DATA_W-1:ADDR_W]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  assign dout          = dout_q;
  assign err           = err_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg_p.sv
// Self-checking bench for router_reg_p: drives FSM state decodes directly and scoreboards dout words.
module tb_router_reg_p;
  localparam int W  = 8;
  localparam int A  = 2;
  localparam int NP = 3;

  logic         clock = 1'b0;
  logic         resetn;
  logic         pkt_valid;
  logic [W-1:0] data_in;
  logic         fifo_full;
  logic         detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic         err, parity_done, low_pkt_valid, len_err;
  logic [W-1:0] dout;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  logic [W-1:0] model_hdr;
  logic [W-1:0] pl[0:7];

  router_reg_p #(.DATA_W(W), .ADDR_W(A), .NUM_PORTS(NP)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .err(err), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .dout(dout), .len_err(len_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0;
  endtask

  // One clock; if a FIFO write is expected this cycle its word is queued, then checked after the edge.
  task automatic tick(input bit wr, input logic [W-1:0] val);
    if (wr) exp_q.push_back(val);
    @(posedge clock);
    @(negedge clock);
    if (wr) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: got=empty exp=word");
      end else begin
        exp_dout = exp_q.pop_front();
      end
    end
    check("dout", dout, exp_dout);
  endtask

  task automatic do_reset();
    detect_add  = 1'($urandom_range(0, 1)); lfd_state  = 1'($urandom_range(0, 1));
    ld_state    = 1'($urandom_range(0, 1)); laf_state  = 1'($urandom_range(0, 1));
    full_state  = 1'($urandom_range(0, 1)); rst_int_reg = 1'($urandom_range(0, 1));
    pkt_valid   = 1'($urandom_range(0, 1)); fifo_full  = 1'($urandom_range(0, 1));
    data_in     = W'($urandom_range(0, 255));
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    idle();
    check("rst_dout", dout, '0);
    check("rst_err", W'(err), '0);
    check("rst_parity_done", W'(parity_done), '0);
    check("rst_low_pkt_valid", W'(low_pkt_valid), '0);
    check("rst_len_err", W'(len_err), '0);
    exp_dout  = '0;
    model_hdr = '0;
    exp_q.delete();
  endtask

  // Sends a packet of n payloads from pl[]; optional stall on one payload or on the parity word.
  task automatic send_pkt(input logic [W-1:0] h, input int n, input int stall_at,
                          input bit stall_par, input bit corrupt);
    logic [W-1:0] par;
    logic [W-1:0] p;
    bit           len_bad;
    idle(); detect_add = 1; pkt_valid = 1; data_in = h;
    if (int'(h[A-1:0]) < NP) model_hdr = h;
    tick(0, '0);
    check("det_err_clr", W'(err), '0);
    check("det_pdone_clr", W'(parity_done), '0);
    idle(); lfd_state = 1; pkt_valid = 1; data_in = h;
    tick(1, model_hdr);
    par = model_hdr;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        idle(); ld_state = 1; pkt_valid = 1; fifo_full = 1; data_in = pl[i];
        tick(0, '0);
        idle(); full_state = 1; pkt_valid = 1; fifo_full = 1; data_in = pl[i];
        tick(0, '0);
        idle(); laf_state = 1; pkt_valid = 1; data_in = pl[i];
        tick(1, pl[i]);
      end else begin
        idle(); ld_state = 1; pkt_valid = 1; data_in = pl[i];
        tick(1, pl[i]);
      end
      par = par ^ pl[i];
    end
    p = corrupt ? (par ^ W'(1)) : par;
    if (stall_par) begin
      idle(); ld_state = 1; fifo_full = 1; data_in = p;
      tick(0, '0);
      check("stall_low_pkt_valid", W'(low_pkt_valid), W'(1));
      check("stall_pdone_wait", W'(parity_done), '0);
      idle(); full_state = 1; fifo_full = 1; data_in = p;
      tick(0, '0);
      idle(); laf_state = 1;
      tick(1, p);
    end else begin
      idle(); ld_state = 1; data_in = p;
      tick(1, p);
    end
    check("parity_done", W'(parity_done), W'(1));
    check("low_pkt_valid", W'(low_pkt_valid), W'(1));
`ifdef ROUTER_REG_LEN_CHECK_EN
    len_bad = (n != int'(model_hdr[W-1:A]));
`else
    len_bad = 1'b0;
`endif
    idle();
    tick(0, '0);
    check("len_err", W'(len_err), W'(len_bad));
    check("err", W'(err), W'((par != p) | len_bad));
    idle(); rst_int_reg = 1;
    tick(0, '0);
    check("lpv_clr", W'(low_pkt_valid), '0);
    check("err_sticky", W'(err), W'((par != p) | len_bad));
  endtask

  initial begin
    idle();
    data_in  = '0;
    resetn   = 1'b0;
    exp_dout = '0;
    do_reset();

    // Header register starts at zero, so an invalid address replays zero.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(8'h0F, 3, -1, 0, 0);
    send_pkt(8'h0E, 3, -1, 0, 0);
    send_pkt(8'h0E, 3, 1, 0, 0);
    send_pkt(8'h0E, 3, -1, 0, 1);
    send_pkt(8'h0F, 3, -1, 0, 0);
    send_pkt(8'h0E, 3, -1, 1, 0);
    send_pkt(8'h0E, 2, -1, 0, 0);

    // Abort mid-packet, then confirm a clean packet afterwards.
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h0D; model_hdr = 8'h0D;
    tick(0, '0);
    idle(); lfd_state = 1; pkt_valid = 1;
    tick(1, model_hdr);
    idle(); ld_state = 1; pkt_valid = 1; data_in = 8'hA5;
    tick(1, 8'hA5);
    do_reset();
    send_pkt(8'h0E, 3, -1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      int n;
      logic [W-1:0] h;
      n = $urandom_range(1, 5);
      h = {6'($urandom_range(1, 5)), 2'($urandom_range(0, NP - 1))};
      for (int j = 0; j < n; j++) pl[j] = W'($urandom_range(0, 255));
      send_pkt(h, n, $urandom_range(0, 1) ? int'($urandom_range(0, n - 1)) : -1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
